// File: rtl/renaming_map.sv
// Register-renaming stage: translates architectural rd/rs1/rs2 of an issue entry into physical
// indices, allocates a free physical register per renamed rd and releases registers on commit.
module renaming_map #(
   parameter int unsigned ARCH_REG_WIDTH = 5,
   parameter int unsigned PHYS_REG_WIDTH = 6,
   parameter int unsigned SBE_REG_WIDTH  = 6,
   parameter int unsigned PAYLOAD_WIDTH  = 16,
   // Flattened entry: {valid, sbe.rd, sbe.rs1, sbe.rs2, payload}
   localparam int unsigned ISSUE_WIDTH = 1 + 3 * SBE_REG_WIDTH + PAYLOAD_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      fetch_entry_ready_i,
   input  logic [ISSUE_WIDTH-1:0]    issue_n,
   output logic [ISSUE_WIDTH-1:0]    issue_q,
   input  logic [PHYS_REG_WIDTH-1:0] waddr_i,
   input  logic                      we_gp_i
);

   localparam int unsigned NUM_ARCH  = 1 << ARCH_REG_WIDTH;
   localparam int unsigned NUM_PHYS  = 1 << PHYS_REG_WIDTH;
   localparam int unsigned VALID_BIT = ISSUE_WIDTH - 1;
   localparam int unsigned RD_LSB    = PAYLOAD_WIDTH + 2 * SBE_REG_WIDTH;
   localparam int unsigned RS1_LSB   = PAYLOAD_WIDTH + SBE_REG_WIDTH;
   localparam int unsigned RS2_LSB   = PAYLOAD_WIDTH;
   localparam logic [NUM_PHYS-1:0] FREE_RESET = {{(NUM_PHYS - 1){1'b1}}, 1'b0};

   logic [PHYS_REG_WIDTH-1:0] r_map  [NUM_ARCH];
   logic [PHYS_REG_WIDTH-1:0] r_prev [NUM_PHYS];
   logic [NUM_PHYS-1:0]       r_free;
   logic [ISSUE_WIDTH-1:0]    r_issue_q;

   logic                      w_valid;
   logic [ARCH_REG_WIDTH-1:0] w_rd_arch;
   logic [ARCH_REG_WIDTH-1:0] w_rs1_arch;
   logic [ARCH_REG_WIDTH-1:0] w_rs2_arch;
   logic [PHYS_REG_WIDTH-1:0] w_rd_old;
   logic [PHYS_REG_WIDTH-1:0] w_rs1_phys;
   logic [PHYS_REG_WIDTH-1:0] w_rs2_phys;
   logic [PHYS_REG_WIDTH-1:0] w_rd_phys;
   logic [PHYS_REG_WIDTH-1:0] w_free_idx;
   logic                      w_free_any;
   logic                      w_rd_nonzero;
   logic                      w_alloc;
   logic                      w_drop;
   logic [PHYS_REG_WIDTH-1:0] w_commit_prev;
   logic                      w_release;
   logic [NUM_PHYS-1:0]       w_free_d;
   logic [ISSUE_WIDTH-1:0]    w_issue_d;

   assign w_valid    = issue_n[VALID_BIT];
   assign w_rd_arch  = issue_n[RD_LSB +: ARCH_REG_WIDTH];
   assign w_rs1_arch = issue_n[RS1_LSB +: ARCH_REG_WIDTH];
   assign w_rs2_arch = issue_n[RS2_LSB +: ARCH_REG_WIDTH];

   // Sources read the pre-update map so rd==rs sees the old mapping.
   assign w_rd_old   = r_map[w_rd_arch];
   assign w_rs1_phys = r_map[w_rs1_arch];
   assign w_rs2_phys = r_map[w_rs2_arch];

   // Lowest-index free register wins.
   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      for (int i = NUM_PHYS - 1; i >= 0; i--) begin
         if (r_free[i]) begin
            w_free_any = 1'b1;
            w_free_idx = PHYS_REG_WIDTH'(i);
         end
      end
   end

   assign w_rd_nonzero = |w_rd_arch;
   assign w_drop       = w_valid & w_rd_nonzero & ~w_free_any;
   assign w_alloc      = fetch_entry_ready_i & w_valid & w_rd_nonzero & w_free_any;
   assign w_rd_phys    = w_alloc ? w_free_idx : w_rd_old;

   // pr0 is never recorded as a victim, so prev==0 means nothing to release.
   assign w_commit_prev = r_prev[waddr_i];
   assign w_release     = we_gp_i & (|w_commit_prev);

   always_comb begin
      w_free_d = r_free;
      if (w_release) begin
         w_free_d[w_commit_prev] = 1'b1;
      end
      if (w_alloc) begin
         w_free_d[w_free_idx] = 1'b0;
      end
   end

   always_comb begin
      w_issue_d                               = issue_n;
      w_issue_d[VALID_BIT]                    = w_valid & ~w_drop;
      w_issue_d[RD_LSB +: SBE_REG_WIDTH]      = SBE_REG_WIDTH'(w_rd_phys);
      w_issue_d[RS1_LSB +: SBE_REG_WIDTH]     = SBE_REG_WIDTH'(w_rs1_phys);
      w_issue_d[RS2_LSB +: SBE_REG_WIDTH]     = SBE_REG_WIDTH'(w_rs2_phys);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_ARCH; i++) begin
            r_map[i] <= '0;
         end
         for (int i = 0; i < NUM_PHYS; i++) begin
            r_prev[i] <= '0;
         end
         r_free    <= FREE_RESET;
         r_issue_q <= '0;
      end else begin
         r_free <= w_free_d;
         if (w_alloc) begin
            r_prev[w_free_idx] <= w_rd_old;
            r_map[w_rd_arch]   <= w_free_idx;
         end
         if (fetch_entry_ready_i) begin
            r_issue_q <= w_issue_d;
         end
      end
   end

   assign issue_q = r_issue_q;

endmodule

// File: tb/tb_renaming_map.sv
// Directed self-checking bench for renaming_map with hand-computed expected entries.
module tb_renaming_map;

   localparam int unsigned W = 1 + 3 * 6 + 16;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         fetch_entry_ready_i = 1'b0;
   logic [W-1:0] issue_n = '0;
   logic [W-1:0] issue_q;
   logic [5:0]   waddr_i = '0;
   logic         we_gp_i = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   renaming_map dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .fetch_entry_ready_i (fetch_entry_ready_i),
      .issue_n             (issue_n),
      .issue_q             (issue_q),
      .waddr_i             (waddr_i),
      .we_gp_i             (we_gp_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [W-1:0] mk(input bit v, input int rd, input int rs1, input int rs2,
                                       input int pl);
      return {v, rd[5:0], rs1[5:0], rs2[5:0], pl[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, got, exp);
   endtask

   task automatic step(input logic [W-1:0] e, input logic rdy, input logic we, input int wa);
      @(negedge clk_i);
      issue_n             = e;
      fetch_entry_ready_i = rdy;
      we_gp_i             = we;
      waddr_i             = wa[5:0];
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      fetch_entry_ready_i = 1'b0;
      we_gp_i             = 1'b0;
   endtask

   initial begin
      #1;
      chk("reset", issue_q, '0);
      #12 rst_ni = 1'b1;

      step(mk(1, 11, 0, 0, 16'h0a00), 1, 0, 0);
      chk("I0", issue_q, mk(1, 1, 0, 0, 16'h0a00));
      step(mk(1, 3, 4, 5, 16'h0a01), 1, 0, 0);
      chk("I1", issue_q, mk(1, 2, 0, 0, 16'h0a01));
      step(mk(1, 5, 0, 0, 16'h0a02), 1, 0, 0);
      chk("I2", issue_q, mk(1, 3, 0, 0, 16'h0a02));
      step(mk(1, 5, 5, 3, 16'h0a03), 1, 0, 0);
      chk("I3", issue_q, mk(1, 4, 3, 2, 16'h0a03));

      for (int p = 1; p <= 4; p++) step(mk(1, 9, 9, 9, 16'hdead), 0, 1, p);
      chk("hold_commit", issue_q, mk(1, 4, 3, 2, 16'h0a03));

      step(mk(1, 8, 11, 0, 16'h0a04), 1, 0, 0);
      chk("I4", issue_q, mk(1, 3, 1, 0, 16'h0a04));
      step(mk(1, 0, 0, 0, 16'h0a05), 1, 0, 0);
      chk("I5", issue_q, mk(1, 0, 0, 0, 16'h0a05));
      step(mk(0, 3, 8, 25, 16'h0a06), 1, 0, 0);
      chk("I6", issue_q, mk(0, 2, 3, 0, 16'h0a06));
      step(mk(1, 7, 3, 6, 16'h0a07), 1, 0, 0);
      chk("I7", issue_q, mk(1, 5, 2, 0, 16'h0a07));
      step(mk(1, 7, 7, 0, 16'h0a08), 1, 0, 0);
      chk("I8", issue_q, mk(1, 6, 5, 0, 16'h0a08));
      step(mk(1, 9, 0, 0, 16'h0bad), 0, 0, 0);
      chk("hold_ready", issue_q, mk(1, 6, 5, 0, 16'h0a08));
      step(mk(1, 9, 7, 0, 16'h0a09), 1, 0, 0);
      chk("I9", issue_q, mk(1, 7, 6, 0, 16'h0a09));
      step(mk(1, 9, 9, 9, 16'hdead), 0, 1, 6);
      step(mk(1, 10, 0, 0, 16'h0a0a), 1, 0, 0);
      chk("I10_reuse", issue_q, mk(1, 5, 0, 0, 16'h0a0a));

      // Exhaust the free list from a clean reset.
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("reset2", issue_q, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 1; i <= 63; i++) begin
         step(mk(1, ((i - 1) % 31) + 1, 0, 0, i), 1, 0, 0);
         chk($sformatf("fill%0d", i), issue_q, mk(1, i, 0, 0, i));
      end
      step(mk(1, 5, 0, 0, 16'h0f00), 1, 0, 0);
      chk("full_drop", issue_q, mk(0, 36, 0, 0, 16'h0f00));
      // Commit of pr40 releases pr9; the same-cycle rename still sees an empty list.
      step(mk(1, 6, 5, 0, 16'h0f01), 1, 1, 40);
      chk("same_cycle", issue_q, mk(0, 37, 36, 0, 16'h0f01));
      step(mk(1, 12, 0, 0, 16'h0f02), 1, 0, 0);
      chk("freed_alloc", issue_q, mk(1, 9, 0, 0, 16'h0f02));
      step(mk(1, 13, 0, 0, 16'h0f03), 1, 0, 0);
      chk("full_again", issue_q, mk(0, 44, 0, 0, 16'h0f03));

      // Asynchronous reset away from the clock edge.
      @(posedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      chk("async_reset", issue_q, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step(mk(1, 11, 5, 0, 16'h0c00), 1, 0, 0);
      chk("post_reset0", issue_q, mk(1, 1, 0, 0, 16'h0c00));
      step(mk(1, 12, 11, 0, 16'h0c01), 1, 0, 0);
      chk("post_reset1", issue_q, mk(1, 2, 1, 0, 16'h0c01));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
